// File: rtl/fp_pkg.sv
// Shared widths and state encoding for the float/fixed converters.
// Used by fpdcvt and by the matching 12-bit-to-float encoder.
package fp_pkg;

  localparam int FP_E_W   = 3;
  localparam int FP_F_W   = 4;
  localparam int FP_D_W   = 12;
  localparam int FP_MAG_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    DONE
  } fpdcvt_state_t;

endpackage

// File: rtl/fpdcvt.sv
// Iterative 8-bit float to 12-bit fixed decoder, one shift per cycle.
// Define FPDCVT_MIDPOINT_EN for midpoint (rather than truncating) reconstruction.
module fpdcvt
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              S,
  input  logic [FP_E_W-1:0] E,
  input  logic [FP_F_W-1:0] F,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_D_W-1:0] D
);

  fpdcvt_state_t r_state;
  fpdcvt_state_t w_nxt;

  logic [FP_MAG_W-1:0] r_mag;
  logic [FP_E_W-1:0]   r_cnt;
  logic                r_s;
  logic [FP_D_W-1:0]   r_d;
  logic                r_ov;
  logic [FP_D_W-1:0]   w_res;
  logic                w_acc;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_ov;
  assign D         = r_d;
  assign w_acc     = in_valid && (r_state == IDLE);

`ifdef FPDCVT_MIDPOINT_EN
  logic [FP_E_W-1:0] r_e;
  logic [FP_D_W-1:0] w_half;

  // Half an LSB of the original exponent, only for non-zero mantissas
  always_comb begin
    w_half = '0;
    if ((r_e != '0) && (r_mag != '0))
      w_half = 12'd1 << (r_e - 3'd1);
  end

  assign w_res = {1'b0, r_mag} + w_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_e <= '0;
    else if (w_acc)
      r_e <= E;
  end
`else
  assign w_res = {1'b0, r_mag};
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (w_acc)
          w_nxt = (E != '0) ? SHIFT : FINISH;
      SHIFT:
        if (r_cnt == 3'd1)
          w_nxt = FINISH;
      FINISH:
        w_nxt = DONE;
      DONE:
        if (out_ready)
          w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mag   <= '0;
      r_cnt   <= '0;
      r_s     <= 1'b0;
      r_d     <= '0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      unique case (r_state)
        IDLE:
          if (w_acc) begin
            r_s   <= S;
            r_cnt <= E;
            r_mag <= {{(FP_MAG_W-FP_F_W){1'b0}}, F};
          end
        SHIFT: begin
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt - 3'd1;
        end
        FINISH: begin
          // Negating zero yields zero, so no negative-zero case
          r_d  <= r_s ? (-w_res) : w_res;
          r_ov <= 1'b1;
        end
        DONE:
          if (out_ready)
            r_ov <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdcvt.sv
// Directed-vector bench for fpdcvt.
// Expectations follow FPDCVT_MIDPOINT_EN when it is defined.
module tb_fpdcvt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int n_chk = 0;
  int n_err = 0;

  fpdcvt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input for exactly the accept edge
  task automatic start(input logic s, input logic [2:0] e,
                       input logic [3:0] f);
    check("in_ready_pre", in_ready, 1);
    S = s; E = e; F = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid, bounded
  task automatic wait_valid(input string tag, input int lat);
    int n;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) check({tag, "_timeout"}, 0, 1);
    else            check({tag, "_lat"}, n, lat);
  endtask

  task automatic run(input string tag, input logic s,
                     input logic [2:0] e, input logic [3:0] f,
                     input logic [11:0] exp);
    start(s, e, f);
    tick();
    wait_valid(tag, e + 1);
    check({tag, "_D"}, D, exp);
    tick();
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_rdy_back"}, in_ready, 1);
  endtask

  logic [11:0] x_max, x_neg, x_hold, x_small;

  initial begin
`ifdef FPDCVT_MIDPOINT_EN
    x_max = 12'h7C0; x_neg = 12'hFB4;
    x_hold = 12'h00E; x_small = 12'h003;
`else
    x_max = 12'h780; x_neg = 12'hFB8;
    x_hold = 12'h00C; x_small = 12'h002;
`endif
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    S = 1'b0; E = '0; F = '0;
    repeat (2) tick();
    check("rst_D", D, 0);
    check("rst_ov", out_valid, 0);
    check("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    tick();

    run("e0f5", 1'b0, 3'd0, 4'd5, 12'h005);
    run("e7f15", 1'b0, 3'd7, 4'd15, x_max);
    run("neg72", 1'b1, 3'd3, 4'd9, x_neg);
    run("negzero", 1'b1, 3'd4, 4'd0, 12'h000);
    run("e0f0", 1'b0, 3'd0, 4'd0, 12'h000);

    // Backpressure: result held, pulsed input ignored
    out_ready = 1'b0;
    start(1'b0, 3'd2, 4'd3);
    tick();
    wait_valid("hold", 3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        S = 1'b1; E = 3'd5; F = 4'd7;
        in_valid = 1'b1;
      end
      check("hold_D", D, x_hold);
      check("hold_ov", out_valid, 1);
      check("hold_rdy", in_ready, 0);
      tick();
      in_valid = 1'b0;
    end
    check("hold_D_end", D, x_hold);
    out_ready = 1'b1;
    tick();
    check("hold_ov_drop", out_valid, 0);
    check("hold_rdy_back", in_ready, 1);

    // Asynchronous reset mid-shift
    start(1'b0, 3'd7, 4'd15);
    tick();
    tick();
    #2;
    check("mid_rdy_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("arst_ov", out_valid, 0);
    check("arst_D", D, 0);
    check("arst_rdy", in_ready, 1);
    tick();
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("arst_no_out", seen, 0);
    end
    run("after_rst", 1'b0, 3'd1, 4'd1, x_small);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
